// File: rtl/uart_serial_port.sv
// Memory-mapped serial endpoint: CPU bytes are buffered and sent as 8N1 UART frames,
// received frames are buffered for the CPU to drain one byte per read strobe.
module uart_serial_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_data_in,
  input  logic       cpu_wren_in,
  input  logic       cpu_rden_in,
  output logic [7:0] cpu_data_out,
  output logic       cpu_valid_out,
  output logic       cpu_ready_out,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       rx_overrun_out,
  output logic       frame_err_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TICK_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // TX FIFO storage and control
  logic [7:0]    r_txf_mem [FIFO_DEPTH];
  logic [AW-1:0] r_txf_wr;
  logic [AW-1:0] r_txf_rd;
  logic [AW:0]   r_txf_cnt;
  logic          w_tx_push;
  logic          w_tx_pop;

  // TX serializer
  state_t        r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_shift;
  logic          r_tx_line;
  logic          w_tx_bit_end;

  // RX synchronizer and deserializer
  logic          r_rx_meta;
  logic          r_rx_sync;
  state_t        r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_shift;
  logic          w_rx_bit_end;
  logic          w_rx_stop_sample;
  logic          w_rx_push_req;
  logic          w_rx_push;
  logic          w_rx_pop;

  // RX FIFO storage and control
  logic [7:0]    r_rxf_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rxf_wr;
  logic [AW-1:0] r_rxf_rd;
  logic [AW:0]   r_rxf_cnt;

  // Sticky error flags
  logic          r_overrun;
  logic          r_frame_err;

  assign w_tx_push    = cpu_wren_in && (r_txf_cnt != CNT_FULL);
  assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
  // The serializer loads the next byte either from idle or straight out of a stop bit.
  assign w_tx_pop     = (r_txf_cnt != '0) &&
                        ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_bit_end));

  assign w_rx_bit_end     = (r_rx_cnt == BIT_LAST);
  assign w_rx_stop_sample = (r_rx_state == S_STOP) && w_rx_bit_end;
  assign w_rx_push_req    = w_rx_stop_sample && r_rx_sync;
  assign w_rx_push        = w_rx_push_req && (r_rxf_cnt != CNT_FULL);
  assign w_rx_pop         = cpu_rden_in && (r_rxf_cnt != '0);

  assign cpu_data_out   = (r_rxf_cnt != '0) ? r_rxf_mem[r_rxf_rd] : 8'h00;
  assign cpu_valid_out  = (r_rxf_cnt != '0);
  assign cpu_ready_out  = (r_txf_cnt != CNT_FULL);
  assign uart_tx_out    = r_tx_line;
  assign rx_overrun_out = r_overrun;
  assign frame_err_out  = r_frame_err;

  // TX FIFO: CPU pushes, serializer pops
  always_ff @(posedge clock) begin
    if (reset) begin
      r_txf_wr  <= '0;
      r_txf_rd  <= '0;
      r_txf_cnt <= '0;
    end else begin
      if (w_tx_push) begin
        r_txf_mem[r_txf_wr] <= cpu_data_in;
        r_txf_wr            <= r_txf_wr + PTR_ONE;
      end
      if (w_tx_pop) begin
        r_txf_rd <= r_txf_rd + PTR_ONE;
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_txf_cnt <= r_txf_cnt + CNT_ONE;
        2'b01:   r_txf_cnt <= r_txf_cnt - CNT_ONE;
        default: r_txf_cnt <= r_txf_cnt;
      endcase
    end
  end

  // TX frame FSM with registered line output
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_tx_cnt <= '0;
          if (w_tx_pop) begin
            r_tx_state <= S_START;
            r_tx_shift <= r_txf_mem[r_txf_rd];
            r_tx_line  <= 1'b0;
          end else begin
            r_tx_line  <= 1'b1;
          end
        end
        S_START: begin
          if (w_tx_bit_end) begin
            r_tx_state <= S_DATA;
            r_tx_cnt   <= '0;
            r_tx_idx   <= 3'd0;
            r_tx_line  <= r_tx_shift[0];
          end else begin
            r_tx_cnt   <= r_tx_cnt + TICK_ONE;
          end
        end
        S_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            if (r_tx_idx == 3'd7) begin
              r_tx_state <= S_STOP;
              r_tx_line  <= 1'b1;
            end else begin
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx_line  <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt   <= r_tx_cnt + TICK_ONE;
          end
        end
        S_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_state <= S_START;
              r_tx_shift <= r_txf_mem[r_txf_rd];
              r_tx_line  <= 1'b0;
            end else begin
              r_tx_state <= S_IDLE;
              r_tx_line  <= 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + TICK_ONE;
          end
        end
        default: begin
          r_tx_state <= S_IDLE;
          r_tx_cnt   <= '0;
          r_tx_line  <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_in;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX frame FSM: mid-start check, then one sample per bit period
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (!r_rx_sync) begin
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= 3'd0;
            r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt   <= r_rx_cnt + TICK_ONE;
          end
        end
        S_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_idx == 3'd7) begin
              r_rx_state <= S_STOP;
            end else begin
              r_rx_idx   <= r_rx_idx + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + TICK_ONE;
          end
        end
        S_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt   <= r_rx_cnt + TICK_ONE;
          end
        end
        default: begin
          r_rx_state <= S_IDLE;
          r_rx_cnt   <= '0;
        end
      endcase
    end
  end

  // RX FIFO: deserializer pushes, CPU pops
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rxf_wr  <= '0;
      r_rxf_rd  <= '0;
      r_rxf_cnt <= '0;
    end else begin
      if (w_rx_push) begin
        r_rxf_mem[r_rxf_wr] <= r_rx_shift;
        r_rxf_wr            <= r_rxf_wr + PTR_ONE;
      end
      if (w_rx_pop) begin
        r_rxf_rd <= r_rxf_rd + PTR_ONE;
      end
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rxf_cnt <= r_rxf_cnt + CNT_ONE;
        2'b01:   r_rxf_cnt <= r_rxf_cnt - CNT_ONE;
        default: r_rxf_cnt <= r_rxf_cnt;
      endcase
    end
  end

  // Sticky flags; a full FIFO drops the byte even if the CPU pops on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_rx_stop_sample) begin
      if (!r_rx_sync) begin
        r_frame_err <= 1'b1;
      end else if (r_rxf_cnt == CNT_FULL) begin
        r_overrun <= 1'b1;
      end else begin
        r_overrun <= r_overrun;
      end
    end else begin
      r_overrun   <= r_overrun;
      r_frame_err <= r_frame_err;
    end
  end

endmodule

// File: tb/tb_uart_serial_port.sv
// Self-checking bench for uart_serial_port: frame-level reference model compared every
// cycle, plus directed literal checks on TX waveform, FIFO limits, RX errors and loopback.
module tb_uart_serial_port;

  localparam int C = 4;
  localparam int D = 4;
  localparam int H = C / 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cpu_data_in = 8'h00;
  logic       cpu_wren_in = 1'b0;
  logic       cpu_rden_in = 1'b0;
  logic [7:0] cpu_data_out;
  logic       cpu_valid_out;
  logic       cpu_ready_out;
  logic       uart_rx_in;
  logic       uart_tx_out;
  logic       rx_overrun_out;
  logic       frame_err_out;
  logic       loop_en = 1'b0;
  logic       drv_rx  = 1'b1;

  assign uart_rx_in = loop_en ? uart_tx_out : drv_rx;

  uart_serial_port #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .cpu_data_in(cpu_data_in), .cpu_wren_in(cpu_wren_in), .cpu_rden_in(cpu_rden_in),
    .cpu_data_out(cpu_data_out), .cpu_valid_out(cpu_valid_out), .cpu_ready_out(cpu_ready_out),
    .uart_rx_in(uart_rx_in), .uart_tx_out(uart_tx_out),
    .rx_overrun_out(rx_overrun_out), .frame_err_out(frame_err_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  int         m_rem = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_meta = 1'b1;
  logic       m_sync = 1'b1;
  bit         m_rx_busy = 1'b0;
  int         m_rx_t = 0;
  logic [7:0] m_rx_byte = 8'h00;
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  bit         m_started = 1'b0;

  // Line level of the frame currently on the wire, derived from position in the frame
  function automatic logic exp_tx_line();
    int pos;
    int b;
    if (m_rem == 0) return 1'b1;
    pos = 10 * C - m_rem;
    b   = pos / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  // Model update at each rising edge using pre-edge inputs
  initial begin
    logic line;
    logic s;
    logic push_req;
    int   pre;
    forever begin
      @(posedge clock);
      line = loop_en ? exp_tx_line() : drv_rx;
      if (reset) begin
        m_txq.delete(); m_rxq.delete();
        m_rem = 0; m_meta = 1'b1; m_sync = 1'b1;
        m_rx_busy = 1'b0; m_rx_t = 0;
        m_ovr = 1'b0; m_ferr = 1'b0;
        m_started = 1'b1;
      end else begin
        s = m_sync; m_sync = m_meta; m_meta = line;
        push_req = 1'b0;
        if (!m_rx_busy) begin
          if (s == 1'b0) begin m_rx_busy = 1'b1; m_rx_t = 0; end
        end else begin
          m_rx_t++;
          if (m_rx_t == H) begin
            if (s) m_rx_busy = 1'b0;
          end else if (m_rx_t > H && m_rx_t < H + 9 * C && ((m_rx_t - H) % C) == 0) begin
            m_rx_byte[(m_rx_t - H) / C - 1] = s;
          end else if (m_rx_t == H + 9 * C) begin
            m_rx_busy = 1'b0;
            if (s) push_req = 1'b1;
            else m_ferr = 1'b1;
          end
        end
        pre = m_rxq.size();
        if (cpu_rden_in && pre > 0) void'(m_rxq.pop_front());
        if (push_req) begin
          if (pre < D) m_rxq.push_back(m_rx_byte);
          else m_ovr = 1'b1;
        end
        pre = m_txq.size();
        if (m_rem <= 1 && pre > 0) begin
          m_cur = m_txq.pop_front();
          m_rem = 10 * C;
        end else if (m_rem > 0) begin
          m_rem--;
        end
        if (cpu_wren_in && pre < D) m_txq.push_back(cpu_data_in);
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clock);
      if (m_started) begin
        check("tx_line", uart_tx_out, exp_tx_line());
        check("ready", cpu_ready_out, m_txq.size() != D);
        check("valid", cpu_valid_out, m_rxq.size() != 0);
        check("rx_data", cpu_data_out, (m_rxq.size() != 0) ? m_rxq[0] : 8'h00);
        check("overrun", rx_overrun_out, m_ovr);
        check("frame_err", frame_err_out, m_ferr);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    cpu_data_in = b;
    cpu_wren_in = 1'b1;
    tick();
    cpu_wren_in = 1'b0;
  endtask

  // Drive one 8N1 frame on the RX line; optionally pulse rden during step pop_at
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at, input int tail);
    for (int i = 0; i < 10 * C + tail; i++) begin
      if (i < C) drv_rx = 1'b0;
      else if (i < 9 * C) drv_rx = b[(i - C) / C];
      else if (i < 10 * C) drv_rx = stop;
      else drv_rx = 1'b1;
      cpu_rden_in = (i == pop_at);
      tick();
    end
    cpu_rden_in = 1'b0;
  endtask

  logic [9:0] a5_pat;
  logic [9:0] got [5];
  logic [9:0] expf;
  logic [7:0] rb [5];

  initial begin
    repeat (3) tick();
    check("rst_tx", uart_tx_out, 1'b1);
    check("rst_ready", cpu_ready_out, 1'b1);
    check("rst_valid", cpu_valid_out, 1'b0);
    check("rst_data", cpu_data_out, 8'h00);
    check("rst_ovr", rx_overrun_out, 1'b0);
    check("rst_ferr", frame_err_out, 1'b0);
    reset = 1'b0;
    tick();

    // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
    a5_pat = 10'b1101001010;
    write_byte(8'hA5);
    for (int i = 0; i < 10 * C; i++) begin
      tick();
      check("txA5_bit", uart_tx_out, a5_pat[i / C]);
    end
    tick();
    check("txA5_idle", uart_tx_out, 1'b1);
    repeat (3) tick();

    // Six consecutive writes into a depth-4 FIFO starting from idle
    cpu_wren_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cpu_data_in = 8'(k + 1);
      tick();
      if (k == 3) check("ready_before_full", cpu_ready_out, 1'b1);
      if (k == 4) check("ready_full", cpu_ready_out, 1'b0);
    end
    cpu_wren_in = 1'b0;
    for (int off = 6; off <= 205; off++) begin
      tick();
      if ((off - 1) % C == H && (off - 1) < 200)
        got[(off - 1) / 40][((off - 1) % 40) / C] = uart_tx_out;
      if (off == 40) check("ready_still_full", cpu_ready_out, 1'b0);
      if (off == 41) check("ready_after_pop", cpu_ready_out, 1'b1);
    end
    for (int f = 0; f < 5; f++) begin
      expf = {1'b1, 8'(f + 1), 1'b0};
      check("txfull_frame", got[f], expf);
    end
    check("txfull_idle", uart_tx_out, 1'b1);

    // Reset in the middle of a frame with bytes still queued
    write_byte(8'h5A); write_byte(8'h66); write_byte(8'h77);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("midrst_tx", uart_tx_out, 1'b1);
    check("midrst_ready", cpu_ready_out, 1'b1);
    reset = 1'b0;
    repeat (6) tick();
    check("midrst_quiet", uart_tx_out, 1'b1);

    // Loopback of three bytes
    loop_en = 1'b1;
    cpu_wren_in = 1'b1;
    cpu_data_in = 8'h3C; tick();
    cpu_data_in = 8'hFF; tick();
    cpu_data_in = 8'h00; tick();
    cpu_wren_in = 1'b0;
    repeat (170) tick();
    check("loop_valid", cpu_valid_out, 1'b1);
    check("loop_b0", cpu_data_out, 8'h3C);
    cpu_rden_in = 1'b1;
    tick();
    check("loop_b1", cpu_data_out, 8'hFF);
    check("loop_valid1", cpu_valid_out, 1'b1);
    tick();
    check("loop_b2", cpu_data_out, 8'h00);
    check("loop_valid2", cpu_valid_out, 1'b1);
    tick();
    cpu_rden_in = 1'b0;
    check("loop_empty", cpu_valid_out, 1'b0);
    check("loop_ovr", rx_overrun_out, 1'b0);
    check("loop_ferr", frame_err_out, 1'b0);
    loop_en = 1'b0;
    repeat (5) tick();

    // One-cycle glitch on idle line
    drv_rx = 1'b0; tick(); drv_rx = 1'b1;
    repeat (20) tick();
    check("glitch_valid", cpu_valid_out, 1'b0);
    check("glitch_ferr", frame_err_out, 1'b0);

    // Frame 0x55 with bad stop bit
    send_frame(8'h55, 1'b0, -1, 20);
    check("ferr_set", frame_err_out, 1'b1);
    check("ferr_nopush", cpu_valid_out, 1'b0);
    check("ferr_noovr", rx_overrun_out, 1'b0);

    // FIFO_DEPTH+1 frames without reading
    for (int f = 0; f < 5; f++) begin
      rb[f] = 8'($urandom);
      send_frame(rb[f], 1'b1, -1, 4);
    end
    repeat (10) tick();
    check("ovr_set", rx_overrun_out, 1'b1);
    for (int f = 0; f < 4; f++) begin
      check("ovr_keep", cpu_data_out, rb[f]);
      cpu_rden_in = 1'b1;
      tick();
    end
    cpu_rden_in = 1'b0;
    check("ovr_drained", cpu_valid_out, 1'b0);

    // Pop on the same edge a new byte is pushed
    send_frame(8'h11, 1'b1, -1, 6);
    check("simul_first", cpu_data_out, 8'h11);
    send_frame(8'h22, 1'b1, 10 * C, 4);
    check("simul_valid", cpu_valid_out, 1'b1);
    check("simul_data", cpu_data_out, 8'h22);
    cpu_rden_in = 1'b1; tick(); cpu_rden_in = 1'b0;
    check("simul_one", cpu_valid_out, 1'b0);

    // Randomized loopback traffic after a fresh reset
    reset = 1'b1; tick(); reset = 1'b0; tick();
    loop_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cpu_wren_in = ($urandom_range(0, 3) == 0);
      cpu_data_in = 8'($urandom);
      cpu_rden_in = ($urandom_range(0, 7) == 0);
      tick();
    end
    cpu_wren_in = 1'b0;
    cpu_rden_in = 1'b0;
    repeat (500) tick();
    loop_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
